// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes rx, samples each bit at its midpoint and
// holds the received byte until it is consumed with rd.
module uart_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       rd,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [2:0]             bit_idx;
    logic [7:0]             shift;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic                   line_armed;

    // NOTE: synchronizer resets to the idle level so reset release never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];
    assign busy = (state != IDLE);

    // NOTE: all state here uses <= so every branch sees pre-edge values (valid, rd) consistently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            data_out   <= '0;
            valid      <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            line_armed <= 1'b1;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (rd && valid) valid <= 1'b0;

            case (state)
                IDLE: begin
                    // After a framing error the line must go high again before a new start.
                    if (rx_s) begin
                        line_armed <= 1'b1;
                    end else if (line_armed) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt            <= '0;
                        shift[bit_idx] <= rx_s;
                        if (bit_idx == 3'd7) state <= STOP;
                        else bit_idx <= bit_idx + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                        if (rx_s) begin
                            // A completion overrides a same-cycle rd: the new byte stays valid.
                            data_out <= shift;
                            valid    <= 1'b1;
                            overrun  <= valid && !rd;
                        end else begin
                            frame_err  <= 1'b1;
                            line_armed <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a frame-level timing model predicts every
// output each cycle; directed scenarios add hand-computed literal checks.
module tb_uart_rx;
    localparam int CPB      = 16;
    localparam int HALF     = CPB / 2;
    // Falling edge driven after cycle t0 -> 2 sync flops + 1 IDLE edge, half bit, 9 bits.
    localparam int DONE_OFS = 3 + HALF + 9 * CPB;

    typedef struct {
        int         t0;
        int         t_end;
        logic [7:0] b;
        logic       stop_bit;
        bit         glitch;
    } frame_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx    = 1'b1;
    logic       rd    = 1'b0;
    logic [7:0] data_out;
    logic       valid, busy, frame_err, overrun;

    uart_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .rd       (rd),
        .data_out (data_out),
        .valid    (valid),
        .busy     (busy),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   rd_edge  = -1;
    logic rd_e     = 1'b0;
    logic rst_e    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rd_e  <= rd;
        rst_e <= rst_n;
    end

    // rd is high for exactly the cycle that is sampled at edge rd_edge.
    initial forever begin
        @(posedge clk);
        #1;
        rd = (cyc + 1 == rd_edge);
    end

    // Model state and output monitors.
    frame_t     q[$];
    logic [7:0] m_data  = 8'h00;
    logic       m_valid = 1'b0;
    logic       m_ferr  = 1'b0;
    logic       m_ovr   = 1'b0;
    logic       m_busy  = 1'b0;
    int         ferr_cnt = 0;
    int         ovr_cnt  = 0;
    int         valid_rise_cyc = -1;
    logic       valid_prev = 1'b0;
    bit         busy_seen  = 1'b0;

    always @(negedge clk) begin
        if (!rst_n || !rst_e) begin
            q.delete();
            m_data  = 8'h00;
            m_valid = 1'b0;
            m_ferr  = 1'b0;
            m_ovr   = 1'b0;
        end else begin
            m_ferr = 1'b0;
            m_ovr  = 1'b0;
            if (q.size() > 0 && !q[0].glitch && q[0].t_end == cyc) begin
                if (q[0].stop_bit) begin
                    m_ovr   = m_valid && !rd_e;
                    m_data  = q[0].b;
                    m_valid = 1'b1;
                end else begin
                    m_ferr = 1'b1;
                end
            end else if (rd_e && m_valid) begin
                m_valid = 1'b0;
            end
            while (q.size() > 0 && cyc >= q[0].t_end) void'(q.pop_front());
        end
        m_busy = (q.size() > 0) && (cyc >= q[0].t0 + 3);

        check($sformatf("data_out@%0d", cyc), data_out, m_data);
        check($sformatf("valid@%0d", cyc), valid, m_valid);
        check($sformatf("busy@%0d", cyc), busy, m_busy);
        check($sformatf("frame_err@%0d", cyc), frame_err, m_ferr);
        check($sformatf("overrun@%0d", cyc), overrun, m_ovr);

        if (frame_err === 1'b1) ferr_cnt++;
        if (overrun === 1'b1) ovr_cnt++;
        if (busy === 1'b1) busy_seen = 1'b1;
        if (valid === 1'b1 && !valid_prev) valid_rise_cyc = cyc;
        valid_prev = (valid === 1'b1);
    end

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Caller is aligned 1 time unit after a rising edge; returns at the end of the stop bit.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit keep_low,
                              input int abort_bit, output int t0);
        frame_t f;
        t0         = cyc;
        f.t0       = cyc;
        f.t_end    = cyc + DONE_OFS;
        f.b        = b;
        f.stop_bit = stop_bit;
        f.glitch   = 1'b0;
        q.push_back(f);
        rx = 1'b0;
        hold(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            if (i == abort_bit) begin
                hold(HALF);
                rst_n = 1'b0;
                hold(3);
                check("busy_in_reset", busy, 1'b0);
                check("valid_in_reset", valid, 1'b0);
                check("data_in_reset", data_out, 8'h00);
                rst_n = 1'b1;
                rx    = 1'b1;
                return;
            end
            hold(CPB);
        end
        rx = stop_bit;
        hold(CPB);
        rx = keep_low ? 1'b0 : 1'b1;
    endtask

    task automatic consume();
        rd_edge = cyc + 2;
        hold(4);
    endtask

    initial begin
        int     t0;
        int     f0;
        int     o0;
        frame_t g;

        hold(5);
        check("rst_data", data_out, 8'h00);
        check("rst_valid", valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ferr", frame_err, 1'b0);
        check("rst_ovr", overrun, 1'b0);
        rst_n = 1'b1;
        hold(3);

        // 0x55 with a low stop bit: framing error, nothing delivered.
        f0 = ferr_cnt;
        send_frame(8'h55, 1'b0, 1'b0, -1, t0);
        hold(4);
        check("ferr_55_count", ferr_cnt - f0, 1);
        check("ferr_55_valid", valid, 1'b0);
        check("ferr_55_data", data_out, 8'h00);

        // 0xA5 clean: valid one clock after the stop-bit sample.
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        send_frame(8'hA5, 1'b1, 1'b0, -1, t0);
        hold(2);
        check("a5_data", data_out, 8'hA5);
        check("a5_valid", valid, 1'b1);
        check("a5_latency", valid_rise_cyc, t0 + DONE_OFS);
        check("a5_ferr", ferr_cnt - f0, 0);
        check("a5_ovr", ovr_cnt - o0, 0);

        // rd clears valid but keeps the byte; rd with valid low does nothing.
        consume();
        check("rd_clear_valid", valid, 1'b0);
        check("rd_keep_data", data_out, 8'hA5);
        consume();
        check("rd_idle_valid", valid, 1'b0);
        check("rd_idle_data", data_out, 8'hA5);

        // 0x3C then 0xC3 back-to-back without rd: one overrun.
        o0 = ovr_cnt;
        send_frame(8'h3C, 1'b1, 1'b0, -1, t0);
        send_frame(8'hC3, 1'b1, 1'b0, -1, t0);
        hold(2);
        check("ovr_data", data_out, 8'hC3);
        check("ovr_valid", valid, 1'b1);
        check("ovr_count", ovr_cnt - o0, 1);

        // rd coincident with the stop sample of 0x7E: no overrun, valid stays.
        o0 = ovr_cnt;
        rd_edge = cyc + DONE_OFS;
        send_frame(8'h7E, 1'b1, 1'b0, -1, t0);
        hold(2);
        check("rdsame_data", data_out, 8'h7E);
        check("rdsame_valid", valid, 1'b1);
        check("rdsame_ovr", ovr_cnt - o0, 0);
        consume();

        // 4-clock low glitch: brief busy, then idle with no outputs.
        f0          = ferr_cnt;
        busy_seen   = 1'b0;
        g.t0        = cyc;
        g.t_end     = cyc + 3 + HALF;
        g.b         = 8'h00;
        g.stop_bit  = 1'b1;
        g.glitch    = 1'b1;
        q.push_back(g);
        rx = 1'b0;
        hold(4);
        rx = 1'b1;
        hold(20);
        check("glitch_busy_seen", busy_seen, 1'b1);
        check("glitch_busy_now", busy, 1'b0);
        check("glitch_valid", valid, 1'b0);
        check("glitch_ferr", ferr_cnt - f0, 0);

        // Break: line stays low after a bad stop bit; one error, no restart.
        f0 = ferr_cnt;
        send_frame(8'h00, 1'b0, 1'b1, -1, t0);
        hold(40);
        check("break_busy", busy, 1'b0);
        rx = 1'b1;
        hold(6);
        check("break_ferr", ferr_cnt - f0, 1);
        check("break_valid", valid, 1'b0);
        send_frame(8'h5A, 1'b1, 1'b0, -1, t0);
        hold(2);
        check("post_break_data", data_out, 8'h5A);
        check("post_break_valid", valid, 1'b1);

        // Reset during bit 4 of 0xFF, then 0x81 is the only byte reported.
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        send_frame(8'hFF, 1'b1, 1'b0, 4, t0);
        hold(20);
        check("abort_valid", valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        send_frame(8'h81, 1'b1, 1'b0, -1, t0);
        hold(2);
        check("after_rst_data", data_out, 8'h81);
        check("after_rst_valid", valid, 1'b1);
        check("after_rst_ferr", ferr_cnt - f0, 0);
        check("after_rst_ovr", ovr_cnt - o0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, SHALL set clk cycles per serial bit (100 MHz / 115200 baud); legal range 4..65535.
REQ-002 Parameter SYNC_STAGES, default 2, SHALL set the number of rx synchronizer flops; legal range 2..3.
REQ-003 clk  input  1  SHALL be the block clock; all state updates on rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 rx  input  1  SHALL be the asynchronous serial line, idle high, 8N1 LSB-first.
REQ-006 rd  input  1  SHALL acknowledge (consume) the held byte when high with valid high.
REQ-007 data_out  output  8  SHALL hold the last received byte.
REQ-008 valid  output  1  SHALL be high while an unconsumed byte is held in data_out.
REQ-009 busy  output  1  SHALL be high whenever the FSM is not in IDLE.
REQ-010 frame_err  output  1  SHALL pulse high one cycle when the stop bit samples low.
REQ-011 overrun  output  1  SHALL pulse high one cycle when a byte completes while valid is still high.

Function
REQ-012 rx SHALL pass through SYNC_STAGES flops before any use; all timing below refers to the synchronized signal rx_s.
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-014 IDLE: on rx_s low, go to START and load the baud counter with 0.
REQ-015 START: at counter = CLKS_PER_BIT/2 - 1 (integer division) sample rx_s; low -> DATA with counter cleared, bit index 0; high -> IDLE (glitch rejected, no output pulse).
REQ-016 DATA: every CLKS_PER_BIT cycles after the start-bit midpoint, sample rx_s into shift register bit [bit index]; after bit index 7 go to STOP.
REQ-017 STOP: CLKS_PER_BIT cycles after bit 7 sample, sample rx_s; then return to IDLE on the same edge.
REQ-018 Stop sample high: data_out SHALL load the shift register and valid SHALL set on the next rising edge.
REQ-019 Stop sample low: frame_err SHALL pulse one cycle, data_out and valid SHALL be unchanged.
REQ-020 Overrun (valid already high at a good stop sample, rd not asserted that cycle): data_out SHALL be overwritten with the new byte, valid SHALL stay high, overrun SHALL pulse one cycle.
REQ-021 rd and a good stop sample in the same cycle: SHALL load the new byte, leave valid high, and not flag overrun.
REQ-022 rd with valid low SHALL be ignored.
REQ-023 rd with valid high and no simultaneous completion SHALL clear valid on the next edge; data_out SHALL retain its value.
REQ-024 The baud counter SHALL be ceil(log2(CLKS_PER_BIT)) bits wide and SHALL never wrap within a bit period.
REQ-025 IDLE after STOP SHALL immediately accept a new falling edge, so back-to-back frames lose no bits.
REQ-026 Latency from stop-bit midpoint to valid high SHALL be exactly 1 clk (plus SYNC_STAGES from the rx pin).
REQ-027 rx held low continuously (break) SHALL produce a frame_err and SHALL NOT restart reception until rx_s returns high.

Reset
REQ-028 Asserting rst_n low SHALL immediately force IDLE, counters 0, shift register 0, data_out 8'h00, valid 0, busy 0, frame_err 0, overrun 0, synchronizer flops 1.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no output pulse; after release, reception SHALL start only on a new falling edge.

Verification (CLKS_PER_BIT=16, SYNC_STAGES=2)
REQ-030 Send 0xA5 8N1, rd low -> valid rises 1 clk after stop midpoint, data_out=8'hA5, frame_err=0, overrun=0.
REQ-031 Send 0x3C then 0xC3 back-to-back without rd -> data_out=8'hC3, valid high, overrun pulses exactly once.
REQ-032 Send 0x55 with the stop bit driven low -> frame_err pulses once, valid stays 0, data_out=8'h00.
REQ-033 rx low pulse of 4 clks from idle -> busy high briefly then IDLE, no valid, no frame_err.
REQ-034 Assert rst_n low during bit 4 of 0xFF, release, then send 0x81 -> only 0x81 reported, valid=1.
REQ-035 Hold valid, assert rd on the same cycle as the stop sample of the next byte 0x7E -> data_out=8'h7E, valid=1, overrun=0.
